// File: rtl/abr_params_pkg.sv
// Shared types and helpers for the masked A2B conversion datapath.
// A masked bit carries its two Boolean shares as [0] and [1].
package abr_params_pkg;

    typedef logic [1:0] masked_bit_t;

    // One stage-0 register, one cycle per bit position, and one output alignment stage.
    function automatic int a2b_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/abr_masked_a2b_lane.sv
// One conversion lane: Boolean remask of both arithmetic shares, a pipelined
// masked ripple-carry adder, and skew registers aligning every sum bit at the output.
module abr_masked_a2b_lane
    import abr_params_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_zeroize,
    input  logic                   i_capture,
    input  logic [WIDTH-1:0][1:0]  i_x,
    input  logic [WIDTH-1:0]       i_rnd,
    input  logic [WIDTH-1:0]       i_rb0,
    input  logic [WIDTH-1:0]       i_rb1,
    output logic [WIDTH-1:0][1:0]  o_s
);

    logic [WIDTH-1:0][1:0] r_a_p0;
    logic [WIDTH-1:0][1:0] r_b_p0;
    logic [WIDTH-1:0]      r_rnd_p0;
    logic [WIDTH-1:0][1:0] w_c;

    // Stage 0: an uncaptured cycle loads zeros so idle lanes never toggle their shares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_p0   <= '0;
            r_b_p0   <= '0;
            r_rnd_p0 <= '0;
        end else if (i_zeroize || !i_capture) begin
            r_a_p0   <= '0;
            r_b_p0   <= '0;
            r_rnd_p0 <= '0;
        end else begin
            for (int j = 0; j < WIDTH; j++) begin
                r_a_p0[j] <= {i_x[j][0] ^ i_rb0[j], i_rb0[j]};
                r_b_p0[j] <= {i_x[j][1] ^ i_rb1[j], i_rb1[j]};
            end
            r_rnd_p0 <= i_rnd;
        end
    end

    assign w_c[0] = '0;

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        masked_bit_t              w_a;
        masked_bit_t              w_b;
        logic                     w_r;
        masked_bit_t              w_s;
        logic [WIDTH-j:1][1:0]    r_s_d;

        // Operand skew: bit j waits j cycles for its carry to ripple in.
        if (j == 0) begin : g_nodly
            assign w_a = r_a_p0[0];
            assign w_b = r_b_p0[0];
            assign w_r = r_rnd_p0[0];
        end else begin : g_dly
            logic [j:1][1:0] r_a_d;
            logic [j:1][1:0] r_b_d;
            logic [j:1]      r_r_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_d <= '0;
                    r_b_d <= '0;
                    r_r_d <= '0;
                end else if (i_zeroize) begin
                    r_a_d <= '0;
                    r_b_d <= '0;
                    r_r_d <= '0;
                end else begin
                    r_a_d[1] <= r_a_p0[j];
                    r_b_d[1] <= r_b_p0[j];
                    r_r_d[1] <= r_rnd_p0[j];
                    for (int k = 2; k <= j; k++) begin
                        r_a_d[k] <= r_a_d[k-1];
                        r_b_d[k] <= r_b_d[k-1];
                        r_r_d[k] <= r_r_d[k-1];
                    end
                end
            end

            assign w_a = r_a_d[j];
            assign w_b = r_b_d[j];
            assign w_r = r_r_d[j];
        end

        if (j < WIDTH - 1) begin : g_fa
            abr_masked_full_adder u_fa (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_zeroize (i_zeroize),
                .i_a       (w_a),
                .i_b       (w_b),
                .i_c       (w_c[j]),
                .i_rnd     (w_r),
                .o_s       (w_s),
                .o_co      (w_c[j+1])
            );
        end else begin : g_msb
            // No carry-out: the sum wraps mod 2^WIDTH; the spare random bit refreshes both shares.
            masked_bit_t r_msb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_msb <= '0;
                end else if (i_zeroize) begin
                    r_msb <= '0;
                end else begin
                    r_msb <= w_a ^ w_b ^ w_c[j] ^ {w_r, w_r};
                end
            end

            assign w_s = r_msb;
        end

        // Output skew: early sum bits wait until the MSB catches up.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s_d <= '0;
            end else if (i_zeroize) begin
                r_s_d <= '0;
            end else begin
                r_s_d[1] <= w_s;
                for (int k = 2; k <= WIDTH - j; k++) begin
                    r_s_d[k] <= r_s_d[k-1];
                end
            end
        end

        assign o_s[j] = r_s_d[WIDTH-j];
    end

endmodule

// File: rtl/abr_masked_full_adder.sv
// Registered two-share masked full adder for one bit position.
// The carry uses maj(a,b,c) = a ^ ((a^b) & (a^c)) with a single masked AND.
module abr_masked_full_adder
    import abr_params_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_zeroize,
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic [1:0] i_c,
    input  logic       i_rnd,
    output logic [1:0] o_s,
    output logic [1:0] o_co
);

    masked_bit_t w_p;
    masked_bit_t w_q;
    masked_bit_t w_t;
    masked_bit_t r_s;
    masked_bit_t r_co;

    assign w_p = i_a ^ i_b;
    assign w_q = i_a ^ i_c;

    // Cross-share products are blinded by the fresh bit before they meet the own-share term.
    assign w_t[0] = (w_p[0] & w_q[0]) ^ ((w_p[0] & w_q[1]) ^ i_rnd);
    assign w_t[1] = (w_p[1] & w_q[1]) ^ ((w_p[1] & w_q[0]) ^ i_rnd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= '0;
        end else if (i_zeroize) begin
            r_s  <= '0;
            r_co <= '0;
        end else begin
            r_s  <= w_p ^ i_c;
            r_co <= i_a ^ w_t;
        end
    end

    assign o_s  = r_s;
    assign o_co = r_co;

endmodule

// File: rtl/abr_masked_a2b_conv_mlane.sv
// Multi-lane masked arithmetic-to-Boolean converter: NUM_LANES pipelined lanes,
// a valid/lane_en tag pipeline matched to the datapath, and an in-flight counter.
module abr_masked_a2b_conv_mlane
    import abr_params_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int NUM_LANES = 4,
    localparam int LATENCY   = a2b_latency(WIDTH),
    localparam int CNT_W     = $clog2(LATENCY + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 zeroize,
    input  logic                                 in_valid,
    input  logic [NUM_LANES-1:0]                 lane_en,
    input  logic [NUM_LANES-1:0][WIDTH-1:0][1:0] x_i,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]      rnd_i,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]      rnd_b0_i,
    input  logic [NUM_LANES-1:0][WIDTH-1:0]      rnd_b1_i,
    output logic                                 out_valid,
    output logic [NUM_LANES-1:0]                 out_lane_en,
    output logic [NUM_LANES-1:0][WIDTH-1:0][1:0] s_o,
    output logic [CNT_W-1:0]                     inflight,
    output logic                                 idle
);

    logic [LATENCY-1:0]                r_vld;
    logic [LATENCY-1:0][NUM_LANES-1:0] r_len;
    logic [CNT_W-1:0]                  r_cnt;
    logic [NUM_LANES-1:0]              w_len_in;
    logic [NUM_LANES-1:0]              w_cap;
    logic                              w_ret;

    assign w_len_in = in_valid ? lane_en : '0;
    assign w_cap    = w_len_in;
    assign w_ret    = r_vld[LATENCY-1];

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        abr_masked_a2b_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_zeroize (zeroize),
            .i_capture (w_cap[l]),
            .i_x       (x_i[l]),
            .i_rnd     (rnd_i[l]),
            .i_rb0     (rnd_b0_i[l]),
            .i_rb1     (rnd_b1_i[l]),
            .o_s       (s_o[l])
        );
    end

    // Tag pipeline: same depth as the datapath so out_valid lines up with s_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_len <= '0;
        end else if (zeroize) begin
            r_vld <= '0;
            r_len <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], in_valid};
            r_len <= {r_len[LATENCY-2:0], w_len_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (zeroize) begin
            r_cnt <= '0;
        end else if (in_valid && !w_ret) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!in_valid && w_ret) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign out_valid   = r_vld[LATENCY-1];
    assign out_lane_en = r_len[LATENCY-1];
    assign inflight    = r_cnt;
    assign idle        = (r_cnt == '0);

endmodule

// File: tb/tb_abr_masked_a2b_conv_mlane.sv
// Scoreboard bench for the multi-lane masked A2B converter (WIDTH=8, four lanes).
module tb_abr_masked_a2b_conv_mlane;

    localparam int W   = 8;
    localparam int NL  = 4;
    localparam int LAT = W + 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       zeroize;
    logic                       in_valid;
    logic [NL-1:0]              lane_en;
    logic [NL-1:0][W-1:0][1:0]  x_i;
    logic [NL-1:0][W-1:0]       rnd_i;
    logic [NL-1:0][W-1:0]       rnd_b0_i;
    logic [NL-1:0][W-1:0]       rnd_b1_i;
    logic                       out_valid;
    logic [NL-1:0]              out_lane_en;
    logic [NL-1:0][W-1:0][1:0]  s_o;
    logic [3:0]                 inflight;
    logic                       idle;

    abr_masked_a2b_conv_mlane #(
        .WIDTH     (W),
        .NUM_LANES (NL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .zeroize     (zeroize),
        .in_valid    (in_valid),
        .lane_en     (lane_en),
        .x_i         (x_i),
        .rnd_i       (rnd_i),
        .rnd_b0_i    (rnd_b0_i),
        .rnd_b1_i    (rnd_b1_i),
        .out_valid   (out_valid),
        .out_lane_en (out_lane_en),
        .s_o         (s_o),
        .inflight    (inflight),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]        en;
        logic [NL-1:0][W-1:0] val;
        int                   stamp;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   peak   = 0;
    int   mon_n;
    logic [NL-1:0][W-1:0] a0, a1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] xor_lane(input int l);
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = s_o[l][b][0] ^ s_o[l][b][1];
        return r;
    endfunction

    // Drive one cycle of stimulus; an accepted vector queues its mod-2^W sums.
    task automatic drive(input logic v, input logic [NL-1:0] en,
                         input logic [NL-1:0][W-1:0] s0, input logic [NL-1:0][W-1:0] s1);
        exp_t e;
        in_valid = v;
        lane_en  = en;
        for (int l = 0; l < NL; l++)
            for (int b = 0; b < W; b++) begin
                x_i[l][b][0] = s0[l][b];
                x_i[l][b][1] = s1[l][b];
            end
        rnd_i    = $urandom;
        rnd_b0_i = $urandom;
        rnd_b1_i = $urandom;
        if (v) begin
            e.en = en;
            for (int l = 0; l < NL; l++) e.val[l] = s0[l] + s1[l];
            e.stamp = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(1'b0, 4'($urandom), $urandom, $urandom);
    endtask

    // Monitor: inflight is the number of queued vectors already past their accept edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_n = 0;
            foreach (q[i]) if (q[i].stamp < cyc) mon_n++;
            check("inflight", 64'(inflight), 64'(mon_n));
            check("idle", 64'(idle), 64'(mon_n == 0));
            if (int'(inflight) > peak) peak = int'(inflight);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 64'(1), 64'(0));
                end else begin
                    cur = q.pop_front();
                    check("latency", 64'(cyc - cur.stamp), 64'(LAT));
                    check("out_lane_en", 64'(out_lane_en), 64'(cur.en));
                    for (int l = 0; l < NL; l++) begin
                        if (cur.en[l]) check("lane_sum", 64'(xor_lane(l)), 64'(cur.val[l]));
                        else           check("lane_off", 64'(s_o[l]), 64'(0));
                    end
                end
            end else if (q.size() > 0 && (cyc - q[0].stamp) >= LAT) begin
                cur = q.pop_front();
                check("missing_out_valid", 64'(0), 64'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; zeroize = 1'b0; in_valid = 1'b0; lane_en = '0;
        x_i = '0; rnd_i = '0; rnd_b0_i = '0; rnd_b1_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_lane_en", 64'(out_lane_en), 64'(0));
        check("rst_s_o", 64'(s_o), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        rst_n = 1'b1;

        // Single vector on lane 0: 200 + 100 wraps to 0x2C
        a0 = '0; a1 = '0; a0[0] = 8'd200; a1[0] = 8'd100;
        drive(1'b1, 4'b0001, a0, a1);
        idle_cycles(12);

        // Wrap-around boundaries
        a0 = {8'h80, 8'h00, 8'hFF, 8'hFF};
        a1 = {8'h80, 8'h00, 8'hFF, 8'h01};
        drive(1'b1, 4'hF, a0, a1);
        idle_cycles(12);

        // 64 back-to-back vectors, all lanes
        peak = 0;
        repeat (64) drive(1'b1, 4'hF, $urandom, $urandom);
        idle_cycles(12);
        check("peak_inflight", 64'(peak), 64'(LAT));

        // Lanes 1 and 3 disabled: their stage-0 registers must never capture
        repeat (16) begin
            drive(1'b1, 4'b0101, $urandom, $urandom);
            check("lane1_stage0_zero", 64'({dut.g_lane[1].u_lane.r_a_p0, dut.g_lane[1].u_lane.r_b_p0,
                                             dut.g_lane[1].u_lane.r_rnd_p0}), 64'(0));
            check("lane3_stage0_zero", 64'({dut.g_lane[3].u_lane.r_a_p0, dut.g_lane[3].u_lane.r_b_p0,
                                             dut.g_lane[3].u_lane.r_rnd_p0}), 64'(0));
        end
        idle_cycles(12);

        // Random valid gaps and lane enables
        repeat (40) drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
        idle_cycles(12);

        // Zeroize 4 cycles after an accept, with in_valid also high to test priority
        drive(1'b1, 4'hF, $urandom, $urandom);
        idle_cycles(3);
        zeroize = 1'b1; in_valid = 1'b1; lane_en = 4'hF;
        @(posedge clk);
        #1;
        q.delete();
        zeroize = 1'b0; in_valid = 1'b0;
        check("zeroize_inflight", 64'(inflight), 64'(0));
        check("zeroize_out_valid", 64'(out_valid), 64'(0));
        check("zeroize_stage0", 64'({dut.g_lane[0].u_lane.r_a_p0, dut.g_lane[0].u_lane.r_b_p0}), 64'(0));
        a0 = {8'h12, 8'hC3, 8'h7F, 8'hAA};
        a1 = {8'hF0, 8'h3D, 8'h81, 8'h56};
        drive(1'b1, 4'hF, a0, a1);
        idle_cycles(12);

        // Asynchronous reset mid-stream
        repeat (5) drive(1'b1, 4'hF, $urandom, $urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_lane_en", 64'(out_lane_en), 64'(0));
        check("arst_s_o", 64'(s_o), 64'(0));
        check("arst_inflight", 64'(inflight), 64'(0));
        check("arst_idle", 64'(idle), 64'(1));
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'b1011, $urandom, $urandom);
        idle_cycles(12);

        check("queue_drained", 64'(q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
